// File: rtl/vram_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vram_axi_pkg
// Brief   : Shared types and constants for the VRAM AXI4 read responder.
// Rev     : 1.0  initial release
// ============================================================================
package vram_axi_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam logic [2:0]  SIZE_32B      = 3'b010;
  localparam logic [31:0] DEF_ADDR_BASE = 32'hC010_0000;
  localparam logic [31:0] DEF_WIN_BYTES = 32'h000C_0000;

  typedef struct packed {
    logic [31:0] data;
    resp_t       resp;
    logic        last;
  } beat_t;

  // Only 32-bit INCR/FIXED bursts are served; anything else is a slave error.
  function automatic logic is_cfg_err(input logic [1:0] burst, input logic [2:0] size);
    return (size != SIZE_32B) || !((burst == BURST_INCR) || (burst == BURST_FIXED));
  endfunction

endpackage
`default_nettype wire

// File: rtl/vram_axi_rd_slave_if.sv
`default_nettype none
// ============================================================================
// Module  : vram_axi_rd_slave_if
// Brief   : AXI4 read-address / read-data channel bundle.
// Rev     : 1.0  initial release
// ============================================================================
interface vram_axi_rd_slave_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast
  );

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );
endinterface
`default_nettype wire

// File: rtl/vram_rd_skid.sv
`default_nettype none
// ============================================================================
// Module  : vram_rd_skid
// Brief   : 2-entry beat buffer with pass-through when empty; occupancy out.
// Rev     : 1.0  initial release
// ============================================================================
module vram_rd_skid
  import vram_axi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  output logic       o_ready,
  input  beat_t      i_beat,
  output logic       o_valid,
  input  logic       i_ready,
  output beat_t      o_beat,
  output logic [1:0] o_count
);

  beat_t      r_mem [2];
  logic       r_wp;
  logic       r_rp;
  logic [1:0] r_cnt;

  logic w_empty;
  logic w_pop;
  logic w_store;
  logic w_pop_buf;

  assign w_empty   = (r_cnt == 2'd0);
  assign o_valid   = !w_empty || i_valid;
  assign o_beat    = w_empty ? i_beat : r_mem[r_rp];
  assign o_ready   = (r_cnt != 2'd2);
  assign o_count   = r_cnt;
  assign w_pop     = o_valid && i_ready;
  // An arriving beat consumed in its own cycle never touches storage.
  assign w_store   = i_valid && !(w_empty && w_pop);
  assign w_pop_buf = w_pop && !w_empty;

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[r_wp] <= i_beat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_store) begin
        r_wp <= ~r_wp;
      end
      if (w_pop_buf) begin
        r_rp <= ~r_rp;
      end
      r_cnt <= r_cnt + {1'b0, w_store} - {1'b0, w_pop_buf};
    end
  end

endmodule
`default_nettype wire

// File: rtl/vram_axi_rd_slave.sv
`default_nettype none
// ============================================================================
// Module  : vram_axi_rd_slave
// Brief   : AXI4 read-only responder streaming framebuffer bursts from VRAM.
//           Define VRAM_RANGE_CHECK_EN to DECERR beats outside the window.
// Rev     : 1.0  initial release
// ============================================================================
module vram_axi_rd_slave
  import vram_axi_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = DEF_ADDR_BASE,
  parameter logic [31:0] WIN_BYTES = DEF_WIN_BYTES,
  parameter int          IDX_W     = 18
) (
  input  logic               clk,
  input  logic               rst,
  vram_axi_rd_slave_if.slave s_axi,
  output logic               mem_en,
  output logic [IDX_W-1:0]   mem_addr,
  input  logic [31:0]        mem_rdata
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [29:0] r_word_off;
  logic [8:0]  r_left;
  logic        r_fixed;
  logic        r_cfg_err;
  logic        r_inflight;
  resp_t       r_inf_resp;
  logic        r_inf_last;

  logic        w_arready;
  logic        w_ar_hs;
  logic [31:0] w_ar_off;
  logic        w_skid_valid;
  logic        w_skid_ready;
  beat_t       w_in_beat;
  beat_t       w_head;
  logic [1:0]  w_cnt;
  logic        w_pop;
  logic [2:0]  w_used;
  logic        w_slot;
  logic        w_in_range;
  resp_t       w_beat_resp;
  logic        w_rvalid;
  logic        w_unused;

  assign w_ar_off   = s_axi.araddr - ADDR_BASE;
  assign w_ar_hs    = s_axi.arvalid && s_axi.arready;
  assign w_pop      = w_skid_valid && s_axi.rready;
  // Credit counts the read in flight plus buffered beats, net of this cycle's pop.
  assign w_used     = {2'b00, r_inflight} + {1'b0, w_cnt} - {2'b00, w_pop};
  assign w_slot     = (r_state == ST_BURST) && (r_left != 9'd0) && (w_used < 3'd2);
  assign w_in_range = (r_word_off < WIN_BYTES[31:2]);

  always_comb begin
    w_beat_resp = RESP_OKAY;
    if (r_cfg_err) begin
      w_beat_resp = RESP_SLVERR;
    end
`ifdef VRAM_RANGE_CHECK_EN
    else if (!w_in_range) begin
      w_beat_resp = RESP_DECERR;
    end
`endif
  end

  assign mem_en   = w_slot && (w_beat_resp == RESP_OKAY) && !rst;
  assign mem_addr = r_word_off[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_arready = 1'b1;
        if (s_axi.arvalid) begin
          w_state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        if (w_pop && w_head.last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word_off <= '0;
      r_left     <= '0;
      r_fixed    <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_inflight <= 1'b0;
      r_inf_resp <= RESP_OKAY;
      r_inf_last <= 1'b0;
    end else begin
      r_inflight <= w_slot;
      r_inf_resp <= w_beat_resp;
      r_inf_last <= (r_left == 9'd1);
      if (w_ar_hs) begin
        r_word_off <= w_ar_off[31:2];
        r_left     <= {1'b0, s_axi.arlen} + 9'd1;
        r_fixed    <= (s_axi.arburst == BURST_FIXED);
        r_cfg_err  <= is_cfg_err(s_axi.arburst, s_axi.arsize);
      end else if (w_slot) begin
        r_left <= r_left - 9'd1;
        if (!r_fixed) begin
          r_word_off <= r_word_off + 30'd1;
        end
      end
    end
  end

  // Error beats travel the same one-cycle slot as real reads to keep the cadence.
  always_comb begin
    w_in_beat.data = (r_inf_resp == RESP_OKAY) ? mem_rdata : 32'd0;
    w_in_beat.resp = r_inf_resp;
    w_in_beat.last = r_inf_last;
  end

  vram_rd_skid u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_valid (r_inflight),
    .o_ready (w_skid_ready),
    .i_beat  (w_in_beat),
    .o_valid (w_skid_valid),
    .i_ready (s_axi.rready),
    .o_beat  (w_head),
    .o_count (w_cnt)
  );

  assign w_rvalid      = w_skid_valid && !rst;
  assign s_axi.arready = w_arready && !rst;
  assign s_axi.rvalid  = w_rvalid;
  assign s_axi.rdata   = w_rvalid ? w_head.data : 32'd0;
  assign s_axi.rresp   = w_rvalid ? w_head.resp : RESP_OKAY;
  assign s_axi.rlast   = w_rvalid && w_head.last;

  assign w_unused = ^{w_ar_off[1:0], r_word_off, w_skid_ready, w_in_range};

endmodule
`default_nettype wire

// File: doc/vram_axi_rd_slave.md
Name: vram_axi_rd_slave

Overview:
AXI4 read-only responder that serves burst reads of the framebuffer from a synchronous single-port video RAM.
- Sits on the memory side of the interconnect, opposite the display fetch master. That master issues 16-beat INCR, 32-bit bursts into the 768 KB window at 0xC010_0000.
- Accepts one AR at a time, reads VRAM one word per cycle, and streams R beats with full rready backpressure.

Parameters:
- ADDR_BASE, 32'hC010_0000: byte base address of the VRAM window.
- WIN_BYTES, 32'h000C_0000: window size in bytes (768 KB).
- IDX_W, 18: VRAM word-index width. Must satisfy 2^IDX_W >= WIN_BYTES/4.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_araddr  in  32  byte address
- s_axi_arlen  in  8  beats minus 1
- s_axi_arsize  in  3  bytes per beat, log2
- s_axi_arburst  in  2  burst type
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  response: 00 OKAY, 10 SLVERR, 11 DECERR
- s_axi_rlast  out  1  last beat of burst
- mem_en  out  1  VRAM read enable
- mem_addr  out  IDX_W  VRAM word index
- mem_rdata  in  32  VRAM data, valid 1 cycle after mem_en

Behaviour:
- Reset: rst is synchronous, active-high, on clock clk. While rst=1 and in the cycle it is sampled, all outputs are 0: arready, rvalid, rlast, rresp, rdata, mem_en. State returns to IDLE.
- Reset mid-burst: the burst is abandoned, in-flight and buffered data are discarded, rvalid=0 the next cycle, and no rlast is emitted.
- IDLE state:
  - arready=1.
  - On arvalid&arready, latch addr, len, size and burst type; set beat_cnt=len; go to BURST.
- BURST state:
  - arready=0.
  - Issue a VRAM read (mem_en=1) only while outstanding reads plus buffered beats < 2.
  - Read data lands in a 2-entry skid buffer. The buffer head drives rvalid, rdata, rresp and rlast.
- Return to IDLE:
  - Happens in the cycle after the handshake of the beat with rlast=1.
  - arready returns to 1 that cycle.
  - No AR overlap and no outstanding transactions.
- Latency:
  - The first rvalid is asserted exactly 2 cycles after the AR handshake.
  - With rready held high, one beat per cycle, no bubbles. A len=15 burst therefore puts rlast on cycle T+17.
- Address index: index = (araddr - ADDR_BASE) >> 2. araddr[1:0] is ignored; the data is word-aligned.
- INCR (arburst=01): index increments by 1 per issued read, modulo 2^IDX_W.
- FIXED (arburst=00): index held for all beats.
- WRAP (10) and reserved (11): every beat returns SLVERR with rdata=0. No mem_en is issued, but beats are still produced at one per cycle.
- arsize other than 3'b010: every beat returns SLVERR with rdata=0. Exactly len+1 beats.
- Beat count: always exactly len+1 beats, whatever the errors. rlast=1 only on the final beat.
- Backpressure:
  - rvalid, rdata, rresp and rlast hold stable while rvalid & !rready.
  - Read issue stalls so the skid buffer never overflows.
  - mem_rdata is captured unconditionally the cycle after mem_en.
- Priority: the same-cycle rlast handshake and the IDLE transition take effect before a new AR is sampled on the following cycle.

Optional Feature:
- Macro: VRAM_RANGE_CHECK_EN.
- Defined: each beat's byte address (base index plus offset) is checked against [ADDR_BASE, ADDR_BASE+WIN_BYTES). Out-of-range beats return DECERR with rdata=0 and issue no mem_en. In-range beats of the same burst return OKAY normally.
- Undefined: no check. The address is truncated to IDX_W bits of word index and aliases; rresp is OKAY unless a burst/size SLVERR applies.

Decomposition:
- Package vram_axi_pkg holds:
  - the resp_t enum (OKAY/SLVERR/DECERR) and the burst_t enum (FIXED/INCR/WRAP);
  - the state_t enum (IDLE/BURST);
  - the constants SIZE_32B=3'b010 and the default base and window values.
- One sub-module, vram_rd_skid: the 2-entry {data,resp,last} buffer with valid/ready on both sides and an occupancy output used for issue credit.

Test Plan:
- Single INCR burst: araddr=0xC010_0040, len=15, size=010, VRAM[i]=i, rready=1 → 16 beats rdata=0x10..0x1F, all OKAY; rlast only on beat 16; first rvalid at T+2; arready=1 at T+18.
- Backpressure: same burst, rready toggles 1-0-0-1 randomly → data order intact, no drops or duplicates, outputs stable while stalled, at most 2 reads outstanding.
- FIXED and error paths:
  - FIXED len=3 at index 5 → four beats of VRAM[5].
  - arburst=10 len=3 → four SLVERR beats, rdata=0, no mem_en.
  - arsize=001 len=0 → one SLVERR beat with rlast.
- Window end, VRAM_RANGE_CHECK_EN defined: araddr=0xC01B_FFF8 len=3 → beats 1-2 OKAY, beats 3-4 DECERR with rdata=0. Undefined → beats 3-4 return VRAM[0x30000], VRAM[0x30001] (aliased), OKAY.
- Reset mid-burst: assert rst after beat 5 of 16 → next cycle rvalid=0; after release arready=1; a new len=0 burst returns the correct single beat.
- Back-to-back: arvalid held high with two queued ARs → the second is accepted only the cycle after the first burst's rlast handshake.
